// File: rtl/cute_key_sequencer.sv
// Cute-Lock key sequencer: stores NUM_KEYS keys and presents the one matching the
// locked FSM's current time window, tracking its counter from a shared sync pulse.
module cute_key_sequencer #(
   parameter int KEY_W    = 12,
   parameter int NUM_KEYS = 4,
   parameter int WINDOW   = 5
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cfg_we,
   input  logic [$clog2(NUM_KEYS)-1:0]           cfg_idx,
   input  logic [KEY_W-1:0]                      cfg_key,
   output logic                                  cfg_err,
   input  logic                                  arm,
   input  logic                                  sync,
   output logic                                  armed,
   output logic [$clog2(NUM_KEYS)-1:0]           win_idx,
   output logic [$clog2(NUM_KEYS*WINDOW)-1:0]    phase,
   output logic [KEY_W-1:0]                      key_out
);

   localparam int P     = NUM_KEYS * WINDOW;
   localparam int IDX_W = $clog2(NUM_KEYS);
   localparam int PH_W  = $clog2(P);
   localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(P - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_RUN} state_t;

   state_t             state, state_nxt;
   logic [KEY_W-1:0]   keys [NUM_KEYS];
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [PH_W-1:0]    phase_nxt;
   logic [IDX_W-1:0]   win_nxt;
   logic [KEY_W-1:0]   key_nxt;
   logic               idx_ok, wr_ok, err_nxt;

   assign idx_ok = (int'(cfg_idx) < NUM_KEYS);
   assign wr_ok  = cfg_we && idx_ok && (state == ST_IDLE);
   assign armed  = (state == ST_RUN);

   always_comb begin
      state_nxt = state;
      phase_nxt = '0;
      cnt_nxt   = '0;
      win_nxt   = '0;
      key_nxt   = '0;
      err_nxt   = cfg_we && !wr_ok;
      case (state)
         ST_IDLE: begin
            if (arm) state_nxt = ST_SYNC;
         end
         ST_SYNC: begin
            if (!arm) begin
               state_nxt = ST_IDLE;
            end else if (sync) begin
               state_nxt = ST_RUN;
               key_nxt   = keys[0];
            end
         end
         ST_RUN: begin
            // arm=0 outranks sync, which outranks normal counting
            if (!arm) begin
               state_nxt = ST_IDLE;
            end else if (sync) begin
               key_nxt = keys[0];
            end else begin
               phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
               if (cnt == CNT_LAST) begin
                  cnt_nxt = '0;
                  win_nxt = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
                  win_nxt = win_idx;
               end
               key_nxt = keys[win_nxt];
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         phase   <= '0;
         cnt     <= '0;
         win_idx <= '0;
         key_out <= '0;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         phase   <= phase_nxt;
         cnt     <= cnt_nxt;
         win_idx <= win_nxt;
         key_out <= key_nxt;
         cfg_err <= err_nxt;
      end
   end

   // Key storage is wiped on reset so a stale key never survives a lock reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
      end else if (wr_ok) begin
         keys[cfg_idx] <= cfg_key;
      end
   end

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Directed bench for cute_key_sequencer: vector table on the default build plus a
// hand-written sequence on a NUM_KEYS=3, WINDOW=2 build.
module tb_cute_key_sequencer;

   logic        clk = 1'b0;
   logic        rst, cfg_we, arm, sync, cfg_err, armed;
   logic [1:0]  cfg_idx, win_idx;
   logic [11:0] cfg_key, key_out;
   logic [4:0]  phase;

   logic        we_b, arm_b, sync_b, err_b, armed_b;
   logic [1:0]  idx_b, win_b;
   logic [11:0] key_b, kout_b;
   logic [2:0]  phase_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cute_key_sequencer #(.KEY_W(12), .NUM_KEYS(4), .WINDOW(5)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
      .cfg_err(cfg_err), .arm(arm), .sync(sync), .armed(armed), .win_idx(win_idx),
      .phase(phase), .key_out(key_out)
   );

   cute_key_sequencer #(.KEY_W(12), .NUM_KEYS(3), .WINDOW(2)) dut_b (
      .clk(clk), .rst(rst), .cfg_we(we_b), .cfg_idx(idx_b), .cfg_key(key_b),
      .cfg_err(err_b), .arm(arm_b), .sync(sync_b), .armed(armed_b), .win_idx(win_b),
      .phase(phase_b), .key_out(kout_b)
   );

   typedef struct {
      logic        rst, we;
      logic [1:0]  idx;
      logic [11:0] key;
      logic        arm, sync;
      logic        e_armed;
      logic [1:0]  e_win;
      logic [4:0]  e_phase;
      logic [11:0] e_key;
      logic        e_err;
   } vec_t;

   vec_t        tv[$];
   int          mp;
   logic [11:0] cur [4];

   function automatic void add(logic r, logic we, logic [1:0] idx, logic [11:0] key,
                               logic a, logic s, logic ea, int ew, int ep,
                               logic [11:0] ek, logic ee);
      vec_t v;
      v.rst = r; v.we = we; v.idx = idx; v.key = key; v.arm = a; v.sync = s;
      v.e_armed = ea; v.e_win = 2'(ew); v.e_phase = 5'(ep); v.e_key = ek; v.e_err = ee;
      tv.push_back(v);
   endfunction

   // One cycle in RUN with arm held high; expected phase follows the 20-cycle period.
   function automatic void run_step(logic we, logic [1:0] idx, logic [11:0] key, logic s);
      mp = s ? 0 : (mp + 1) % 20;
      add(1'b0, we, idx, key, 1'b1, s, 1'b1, mp / 5, mp, cur[mp / 5], we);
   endfunction

   function automatic void idle_vec(logic r, logic we, logic [1:0] idx, logic [11:0] key,
                                    logic a, logic s, logic ee);
      add(r, we, idx, key, a, s, 1'b0, 0, 0, 12'd0, ee);
   endfunction

   task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at step %0d: got %0d, expected %0d", nm, i, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; arm = 1'b0; sync = 1'b0;
      we_b = 1'b0; idx_b = '0; key_b = '0; arm_b = 1'b0; sync_b = 1'b0;

      idle_vec(1, 0, 0, 0, 0, 0, 0);
      idle_vec(0, 1, 0, 12'd734, 0, 0, 0);
      idle_vec(0, 1, 1, 12'd835, 0, 0, 0);
      idle_vec(0, 1, 2, 12'd2660, 0, 0, 0);
      idle_vec(0, 1, 3, 12'd1905, 0, 0, 0);
      idle_vec(0, 0, 0, 0, 1, 0, 0);
      idle_vec(0, 0, 0, 0, 1, 0, 0);
      cur = '{12'd734, 12'd835, 12'd2660, 12'd1905};
      run_step(0, 0, 0, 1);
      for (int k = 0; k < 20; k++) run_step(0, 0, 0, 0);
      run_step(1, 1, 12'hFFF, 0);
      for (int k = 0; k < 12; k++) run_step(0, 0, 0, 0);
      run_step(0, 0, 0, 1);
      for (int k = 0; k < 7; k++) run_step(0, 0, 0, 0);
      idle_vec(0, 0, 0, 0, 0, 0, 0);
      idle_vec(0, 0, 0, 0, 1, 0, 0);
      idle_vec(0, 0, 0, 0, 1, 0, 0);
      idle_vec(0, 1, 0, 12'h123, 1, 0, 1);
      idle_vec(0, 0, 0, 0, 1, 0, 0);
      run_step(0, 0, 0, 1);
      for (int k = 0; k < 17; k++) run_step(0, 0, 0, 0);
      idle_vec(1, 0, 0, 0, 1, 0, 0);
      idle_vec(0, 0, 0, 0, 1, 0, 0);
      cur = '{12'd0, 12'd0, 12'd0, 12'd0};
      run_step(0, 0, 0, 1);
      for (int k = 0; k < 20; k++) run_step(0, 0, 0, 0);
      idle_vec(0, 0, 0, 0, 0, 0, 0);
      idle_vec(0, 1, 2, 12'hABC, 1, 0, 0);
      cur = '{12'd0, 12'd0, 12'hABC, 12'd0};
      run_step(0, 0, 0, 1);
      for (int k = 0; k < 15; k++) run_step(0, 0, 0, 0);

      foreach (tv[i]) begin
         rst = tv[i].rst; cfg_we = tv[i].we; cfg_idx = tv[i].idx; cfg_key = tv[i].key;
         arm = tv[i].arm; sync = tv[i].sync;
         cyc();
         chk("armed",   i, 32'(armed),   32'(tv[i].e_armed));
         chk("win_idx", i, 32'(win_idx), 32'(tv[i].e_win));
         chk("phase",   i, 32'(phase),   32'(tv[i].e_phase));
         chk("key_out", i, 32'(key_out), 32'(tv[i].e_key));
         chk("cfg_err", i, 32'(cfg_err), 32'(tv[i].e_err));
      end
      rst = 1'b0; cfg_we = 1'b0; arm = 1'b0; sync = 1'b0;

      // Small build: out-of-range slot write, then a full 6-cycle period with wrap
      we_b = 1'b1; idx_b = 2'd0; key_b = 12'h111; cyc();
      chk("b_err_w0", 0, 32'(err_b), 32'd0);
      idx_b = 2'd1; key_b = 12'h222; cyc();
      idx_b = 2'd2; key_b = 12'h333; cyc();
      idx_b = 2'd3; key_b = 12'h777; cyc();
      chk("b_err_oor", 0, 32'(err_b), 32'd1);
      we_b = 1'b0; cyc();
      chk("b_err_clr", 0, 32'(err_b), 32'd0);
      arm_b = 1'b1; cyc();
      chk("b_armed_sync", 0, 32'(armed_b), 32'd0);
      chk("b_key_sync", 0, 32'(kout_b), 32'd0);
      sync_b = 1'b1; cyc(); sync_b = 1'b0;
      chk("b_armed", 0, 32'(armed_b), 32'd1);
      chk("b_phase", 0, 32'(phase_b), 32'd0);
      chk("b_key", 0, 32'(kout_b), 32'h111);
      for (int k = 1; k <= 7; k++) begin
         logic [11:0] bk [3];
         bk = '{12'h111, 12'h222, 12'h333};
         cyc();
         chk("b_phase", k, 32'(phase_b), 32'(k % 6));
         chk("b_win", k, 32'(win_b), 32'((k % 6) / 2));
         chk("b_key", k, 32'(kout_b), 32'(bk[(k % 6) / 2]));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
